// File: rtl/imem_loader.sv
// Program memory for the 8-bit CPU with a switch/button loader.
// Holds the CPU in reset while the operator keys a program in.
module imem_loader #(
    parameter int         DEPTH = 32,
    parameter logic [7:0] FILL  = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] address,
    output logic [7:0] instruction,
    input  logic       prog_mode,
    input  logic [7:0] prog_data,
    input  logic       prog_strobe,
    output logic       cpu_hold,
    output logic [7:0] prog_ptr,
    output logic       full,
    output logic [1:0] state
);

    localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] LIM = 9'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } st_t;

    st_t        st;
    logic [7:0] mem [DEPTH];
    logic [8:0] ptr;
    logic       hold_q;
    logic       full_q;
    logic       mode_m;
    logic       mode_s;
    logic       strb_m;
    logic       strb_s;
    logic       strb_d;
    logic       pulse;
    logic       rd_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_m <= 1'b0;
            mode_s <= 1'b0;
            strb_m <= 1'b0;
            strb_s <= 1'b0;
            strb_d <= 1'b0;
        end else begin
            mode_m <= prog_mode;
            mode_s <= mode_m;
            strb_m <= prog_strobe;
            strb_s <= strb_m;
            strb_d <= strb_s;
        end
    end

    // One pulse per press, however long the button is held
    assign pulse = strb_s & ~strb_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st     <= IDLE;
            ptr    <= '0;
            full_q <= 1'b0;
            hold_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= FILL;
            end
        end else begin
            unique case (st)
                IDLE: begin
                    if (mode_s) begin
                        st     <= LOAD;
                        ptr    <= '0;
                        full_q <= 1'b0;
                    end else begin
                        st     <= RUN;
                        hold_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (pulse && (ptr < LIM)) begin
                        mem[ptr[AW-1:0]] <= prog_data;
                        ptr              <= ptr + 9'd1;
                        full_q           <= (ptr + 9'd1 == LIM);
                    end
                    // A pulse landing with the mode drop is still stored
                    if (!mode_s) begin
                        st     <= RUN;
                        hold_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (mode_s) begin
                        st     <= LOAD;
                        ptr    <= '0;
                        full_q <= 1'b0;
                        hold_q <= 1'b1;
                    end
                end
                default: begin
                    st     <= IDLE;
                    hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign rd_ok       = ({1'b0, address} < LIM);
    assign instruction = rd_ok ? mem[address[AW-1:0]] : FILL;
    assign cpu_hold    = hold_q;
    assign prog_ptr    = ptr[7:0];
    assign full        = full_q;
    assign state       = st;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: read tables plus
// hand sequences for press timing, bounds and reset.
module tb_imem_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] instruction;
    logic       prog_mode;
    logic [7:0] prog_data;
    logic       prog_strobe;
    logic       cpu_hold;
    logic [7:0] prog_ptr;
    logic       full;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         grp;
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_t;

    rd_t tbl [16];

    always #5 clock = ~clock;

    imem_loader #(
        .DEPTH(4),
        .FILL (8'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .instruction(instruction),
        .prog_mode  (prog_mode),
        .prog_data  (prog_data),
        .prog_strobe(prog_strobe),
        .cpu_hold   (cpu_hold),
        .prog_ptr   (prog_ptr),
        .full       (full),
        .state      (state)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [7:0] d);
        prog_data   = d;
        prog_strobe = 1'b1;
        cyc(3);
        prog_strobe = 1'b0;
        cyc(3);
    endtask

    task automatic run_grp(input int g);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].grp == g) begin
                address = tbl[i].addr;
                #1;
                chk($sformatf("rd_g%0d_a%0d", g, tbl[i].addr),
                    instruction, tbl[i].exp);
            end
        end
    endtask

    task automatic new_session();
        prog_mode = 1'b0;
        cyc(4);
        prog_mode = 1'b1;
        cyc(4);
    endtask

    initial begin
        logic hit;
        tbl[0]  = '{1, 8'd0,   8'h00};
        tbl[1]  = '{1, 8'd5,   8'h00};
        tbl[2]  = '{1, 8'd200, 8'h00};
        tbl[3]  = '{2, 8'd0,   8'h41};
        tbl[4]  = '{2, 8'd1,   8'h9C};
        tbl[5]  = '{2, 8'd2,   8'hC3};
        tbl[6]  = '{2, 8'd3,   8'h00};
        tbl[7]  = '{4, 8'd0,   8'h01};
        tbl[8]  = '{4, 8'd1,   8'h02};
        tbl[9]  = '{4, 8'd2,   8'h03};
        tbl[10] = '{4, 8'd3,   8'h04};
        tbl[11] = '{4, 8'd4,   8'h00};
        tbl[12] = '{5, 8'd0,   8'h7E};
        tbl[13] = '{5, 8'd1,   8'h02};
        tbl[14] = '{5, 8'd2,   8'h03};
        tbl[15] = '{5, 8'd255, 8'h00};

        reset       = 1'b0;
        address     = 8'd0;
        prog_mode   = 1'b0;
        prog_data   = 8'h00;
        prog_strobe = 1'b0;
        cyc(2);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_hold", {7'd0, cpu_hold}, 8'd1);
        chk("rst_ptr", prog_ptr, 8'd0);
        chk("rst_full", {7'd0, full}, 8'd0);

        // Test 1: boot straight into RUN
        reset = 1'b1;
        #1;
        chk("t1_idle", {6'd0, state}, 8'd0);
        cyc(3);
        chk("t1_run", {6'd0, state}, 8'd2);
        chk("t1_hold", {7'd0, cpu_hold}, 8'd0);
        run_grp(1);

        // Test 2: three-byte program
        prog_mode = 1'b1;
        cyc(4);
        chk("t2_load", {6'd0, state}, 8'd1);
        chk("t2_hold_load", {7'd0, cpu_hold}, 8'd1);
        chk("t2_ptr0", prog_ptr, 8'd0);
        press(8'h41);
        chk("t2_hold_p1", {7'd0, cpu_hold}, 8'd1);
        press(8'h9C);
        press(8'hC3);
        chk("t2_hold_p3", {7'd0, cpu_hold}, 8'd1);
        prog_mode = 1'b0;
        cyc(4);
        chk("t2_run", {6'd0, state}, 8'd2);
        chk("t2_hold_run", {7'd0, cpu_hold}, 8'd0);
        chk("t2_ptr3", prog_ptr, 8'd3);
        chk("t2_full", {7'd0, full}, 8'd0);
        run_grp(2);

        // Test 3: long press, single write on third edge
        prog_mode = 1'b1;
        cyc(4);
        chk("t3_ptr0", prog_ptr, 8'd0);
        address     = 8'd0;
        prog_data   = 8'h5A;
        prog_strobe = 1'b1;
        cyc(1);
        chk("t3_e1", instruction, 8'h41);
        cyc(1);
        chk("t3_e2", instruction, 8'h41);
        cyc(1);
        chk("t3_e3", instruction, 8'h5A);
        chk("t3_ptr_e3", prog_ptr, 8'd1);
        cyc(17);
        prog_strobe = 1'b0;
        cyc(3);
        chk("t3_ptr_end", prog_ptr, 8'd1);
        address = 8'd1;
        #1;
        chk("t3_w1", instruction, 8'h9C);

        // Test 4: overfill a 4-word memory
        new_session();
        chk("t4_ptr0", prog_ptr, 8'd0);
        for (int i = 1; i <= 6; i++) begin
            press(8'(i));
            if (i == 3) chk("t4_full3", {7'd0, full}, 8'd0);
            if (i == 4) begin
                chk("t4_full4", {7'd0, full}, 8'd1);
                chk("t4_ptr4", prog_ptr, 8'd4);
            end
        end
        chk("t4_ptr6", prog_ptr, 8'd4);
        chk("t4_full6", {7'd0, full}, 8'd1);
        run_grp(4);

        // Test 5: RUN ignores presses; reload keeps tail words
        prog_mode = 1'b0;
        cyc(4);
        chk("t5_ptr_kept", prog_ptr, 8'd4);
        chk("t5_full_kept", {7'd0, full}, 8'd1);
        press(8'hFF);
        chk("t5_run_ptr", prog_ptr, 8'd4);
        run_grp(4);
        prog_mode = 1'b1;
        cyc(4);
        chk("t5_ptr0", prog_ptr, 8'd0);
        chk("t5_full0", {7'd0, full}, 8'd0);
        press(8'h7E);
        run_grp(5);

        // Pulse and mode drop in the same LOAD cycle
        prog_data   = 8'h33;
        prog_strobe = 1'b1;
        prog_mode   = 1'b0;
        cyc(3);
        chk("sim_state", {6'd0, state}, 8'd2);
        chk("sim_ptr", prog_ptr, 8'd2);
        address = 8'd1;
        #1;
        chk("sim_w1", instruction, 8'h33);
        prog_strobe = 1'b0;
        cyc(3);

        // Test 6: reset mid-load
        prog_mode = 1'b1;
        cyc(4);
        press(8'hA1);
        press(8'hA2);
        chk("t6_ptr2", prog_ptr, 8'd2);
        reset = 1'b0;
        #1;
        chk("t6_ptr_rst", prog_ptr, 8'd0);
        chk("t6_state_rst", {6'd0, state}, 8'd0);
        chk("t6_hold_rst", {7'd0, cpu_hold}, 8'd1);
        address = 8'd0;
        #1;
        chk("t6_w0", instruction, 8'h00);
        address = 8'd1;
        #1;
        chk("t6_w1", instruction, 8'h00);
        cyc(1);
        reset = 1'b1;
        #1;
        chk("t6_idle", {6'd0, state}, 8'd0);
        chk("t6_hold", {7'd0, cpu_hold}, 8'd1);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (state == 2'd1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_reload", {7'd0, hit}, 8'd1);
        chk("t6_hold_load", {7'd0, cpu_hold}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
